// File: rtl/solution_search_ctrl.sv
// Sequencer that walks LFSR candidates through a combinational constraint checker and tracks the best hit.
// Latency: start->first chk_valid 1 cycle; each candidate costs >=2 cycles (handshake + result).
// Backpressure: chk_cand is held stable while chk_ready is low; one candidate outstanding at most.
module solution_search_ctrl #(
  parameter int                CAND_W = 64,
  parameter int                NUM_C  = 22,
  parameter int                TRY_W  = 16,
  parameter logic [CAND_W-1:0] POLY   = 64'hD800000000000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [CAND_W-1:0]            seed,
  input  logic [TRY_W-1:0]             max_tries,
  output logic                         chk_valid,
  input  logic                         chk_ready,
  output logic [CAND_W-1:0]            chk_cand,
  input  logic                         res_valid,
  input  logic [NUM_C-1:0]             res_vec,
  output logic                         busy,
  output logic                         done,
  output logic                         found,
  output logic [CAND_W-1:0]            solution,
  output logic [TRY_W-1:0]             tries,
  output logic [CAND_W-1:0]            best_cand,
  output logic [$clog2(NUM_C+1)-1:0]   best_score
);

  localparam int SCORE_W = $clog2(NUM_C + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Generator state, the candidate currently awaiting its result, and the latched budget
  logic [CAND_W-1:0] lfsr;
  logic [CAND_W-1:0] lfsr_nxt;
  logic [CAND_W-1:0] issued;
  logic [TRY_W-1:0]  budget;

  // Per-cycle decode of the interesting events
  logic               start_ok;
  logic               hs;
  logic               res_take;
  logic               sat;
  logic               last_try;
  logic [SCORE_W-1:0] score;

  // Number of satisfied constraints in one result vector
  function automatic logic [SCORE_W-1:0] popcount(input logic [NUM_C-1:0] v);
    logic [SCORE_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_C; i++) begin
      cnt = cnt + SCORE_W'(v[i]);
    end
    return cnt;
  endfunction

  // Event decode; abort takes priority over start, and start is only honoured when not busy
  always_comb begin
    start_ok = start && !abort && ((state == S_IDLE) || (state == S_DONE));
    hs       = (state == S_ISSUE) && chk_ready;
    res_take = (state == S_WAIT) && res_valid;
    sat      = &res_vec;
    score    = popcount(res_vec);
    last_try = ((tries + TRY_W'(1)) == budget);
    lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ POLY) : (lfsr >> 1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_nxt = state;
    chk_valid = 1'b0;
    chk_cand  = '0;
    busy      = 1'b0;
    done      = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start_ok) begin
          state_nxt = (max_tries == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        chk_valid = 1'b1;
        chk_cand  = lfsr;
        busy      = 1'b1;
        if (hs) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (res_take) begin
          if (sat || last_try) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start_ok) begin
          state_nxt = (max_tries == '0) ? S_DONE : S_ISSUE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (abort) begin
      state_nxt = S_IDLE;
    end
  end

  // Datapath: LFSR, try counter, result capture and best-candidate tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr       <= CAND_W'(1);
      issued     <= '0;
      budget     <= '0;
      tries      <= '0;
      found      <= 1'b0;
      solution   <= '0;
      best_cand  <= '0;
      best_score <= '0;
    end else if (abort) begin
      // Abort drops the verdict but keeps the statistics for the caller to inspect
      found <= 1'b0;
    end else begin
      if (start_ok) begin
        lfsr       <= (seed == '0) ? CAND_W'(1) : seed;
        budget     <= max_tries;
        tries      <= '0;
        found      <= 1'b0;
        solution   <= '0;
        best_cand  <= '0;
        best_score <= '0;
      end
      if (hs) begin
        issued <= lfsr;
        lfsr   <= lfsr_nxt;
      end
      if (res_take) begin
        tries <= tries + TRY_W'(1);
        // Strict compare: ties keep the earlier candidate
        if (score > best_score) begin
          best_cand  <= issued;
          best_score <= score;
        end
        if (sat) begin
          solution <= issued;
          found    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_solution_search_ctrl.sv
// Bench for solution_search_ctrl with an 8-bit candidate, 4 constraints and POLY 8'hB8.
// Expected candidates come from a reference LFSR and are queued at start, popped at each handshake.
// Checker responses are queued per search and fed back one cycle after each handshake.
module tb_solution_search_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  seed;
  logic [15:0] max_tries;
  logic        chk_valid;
  logic        chk_ready;
  logic [7:0]  chk_cand;
  logic        res_valid;
  logic [3:0]  res_vec;
  logic        busy;
  logic        done;
  logic        found;
  logic [7:0]  solution;
  logic [15:0] tries;
  logic [7:0]  best_cand;
  logic [2:0]  best_score;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];
  logic [3:0] resp_q[$];

  always #5 clk = ~clk;

  solution_search_ctrl #(
    .CAND_W (8),
    .NUM_C  (4),
    .TRY_W  (16),
    .POLY   (8'hB8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .seed       (seed),
    .max_tries  (max_tries),
    .chk_valid  (chk_valid),
    .chk_ready  (chk_ready),
    .chk_cand   (chk_cand),
    .res_valid  (res_valid),
    .res_vec    (res_vec),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .solution   (solution),
    .tries      (tries),
    .best_cand  (best_cand),
    .best_score (best_score)
  );

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!chk_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("chk_valid_timeout", chk_valid, 1);
  endtask

  // Start a search, serve n_exp candidates from resp_q; ready held low for 'hold' cycles on the first
  task automatic run_search(input logic [7:0] sd, input logic [15:0] mt, input int n_exp, input int hold);
    logic [7:0] l;
    l = (sd == 8'h00) ? 8'h01 : sd;
    for (int i = 0; i < n_exp; i++) begin
      exp_q.push_back(l);
      l = lfsr_step(l);
    end
    chk_ready = (hold == 0);
    seed      = sd;
    max_tries = mt;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n_exp; i++) begin
      wait_valid();
      if (i == 0) begin
        for (int k = 0; k < hold; k++) begin
          check("hold_cand", chk_cand, exp_q[0]);
          check("hold_vld", chk_valid, 1);
          @(negedge clk);
        end
      end
      chk_ready = 1'b1;
      check("cand", chk_cand, exp_q.pop_front());
      @(negedge clk);
      check("wait_no_vld", chk_valid, 0);
      res_valid = 1'b1;
      res_vec   = resp_q.pop_front();
      @(negedge clk);
      res_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    seed      = 8'h00;
    max_tries = 16'd0;
    chk_ready = 1'b0;
    res_valid = 1'b0;
    res_vec   = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_vld", chk_valid, 0);
    check("rst_cand", chk_cand, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_found", found, 0);
    check("rst_tries", tries, 0);
    check("rst_best", best_score, 0);
    check("rst_sol", solution, 0);

    // 1: budget exhausted, no full hit
    resp_q = '{4'b0111, 4'b0111, 4'b0111};
    run_search(8'h01, 16'd3, 3, 0);
    check("t1_done", done, 1);
    check("t1_found", found, 0);
    check("t1_tries", tries, 3);
    check("t1_best_score", best_score, 3);
    check("t1_best_cand", best_cand, 8'h01);
    repeat (2) @(negedge clk);
    check("t1_done_held", done, 1);
    check("t1_no_vld", chk_valid, 0);

    // 2: full hit on the third candidate
    resp_q = '{4'b0111, 4'b0111, 4'b1111};
    run_search(8'h01, 16'd10, 3, 0);
    check("t2_done", done, 1);
    check("t2_found", found, 1);
    check("t2_solution", solution, 8'h5C);
    check("t2_tries", tries, 3);
    check("t2_best_score", best_score, 4);
    check("t2_best_cand", best_cand, 8'h5C);

    // 3: zero seed replaced by 1
    resp_q = '{4'b0001};
    run_search(8'h00, 16'd1, 1, 0);
    check("t3_done", done, 1);
    check("t3_tries", tries, 1);
    check("t3_best_score", best_score, 1);
    check("t3_found", found, 0);

    // 4: zero budget goes straight to done
    run_search(8'h33, 16'd0, 0, 0);
    check("t4_done", done, 1);
    check("t4_no_vld", chk_valid, 0);
    check("t4_tries", tries, 0);
    check("t4_found", found, 0);
    check("t4_best_score", best_score, 0);

    // 5: ready held low, candidate must stay put
    resp_q = '{4'b1111};
    run_search(8'h01, 16'd1, 1, 5);
    check("t5_tries", tries, 1);
    check("t5_found", found, 1);
    check("t5_solution", solution, 8'h01);

    // 6: abort while waiting for a result, then a stray result
    chk_ready = 1'b1;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hB8);
    seed      = 8'h01;
    max_tries = 16'd5;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid();
    check("t6_cand0", chk_cand, exp_q.pop_front());
    @(negedge clk);
    res_valid = 1'b1;
    res_vec   = 4'b0011;
    @(negedge clk);
    res_valid = 1'b0;
    wait_valid();
    check("t6_cand1", chk_cand, exp_q.pop_front());
    @(negedge clk);
    check("t6_in_wait", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_found", found, 0);
    check("t6_tries", tries, 1);
    check("t6_best_score", best_score, 2);
    check("t6_best_cand", best_cand, 8'h01);
    res_valid = 1'b1;
    res_vec   = 4'b1111;
    @(negedge clk);
    res_valid = 1'b0;
    @(negedge clk);
    check("t6_stray_tries", tries, 1);
    check("t6_stray_found", found, 0);
    check("t6_stray_vld", chk_valid, 0);

    // Clean restart after abort
    resp_q = '{4'b0111, 4'b0111, 4'b0111};
    run_search(8'h01, 16'd3, 3, 0);
    check("t6r_done", done, 1);
    check("t6r_tries", tries, 3);
    check("t6r_best_score", best_score, 3);
    check("t6r_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
